// File: rtl/car_pkg.sv
// Shared widths, FSM encodings and saturation limits for the B1 carrier wipe-off and accumulate path.
package car_pkg;

   localparam int unsigned ADC_WIDTH_DEF = 8;
   localparam int unsigned CAR_WIDTH_DEF = 8;
   localparam int unsigned ACC_WIDTH_DEF = 24;

   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } acc_state_e;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } out_state_e;

   // Saturation limits of a w-bit two's-complement accumulator, w <= 63
   function automatic logic signed [63:0] sat_max(input int unsigned w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int unsigned w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/car_acc_chan.sv
// One correlator arm: code-sign stage (P2), saturating integrate-and-dump with a per-epoch sat flag.
module car_acc_chan
   import car_pkg::*;
#(
   parameter int unsigned MUL_WIDTH = ADC_WIDTH_DEF + CAR_WIDTH_DEF,
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [MUL_WIDTH-1:0] prod,
   input  logic                        code,
   input  logic                        prod_valid,
   input  logic                        term_valid,
   input  logic                        term_dump,
   input  logic                        run,
   output logic signed [ACC_WIDTH-1:0] sum_c,
   output logic                        sat_c
);

   localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic signed [ACC_WIDTH-1:0] term_d, term_q;
   logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
   logic                        sat_d, sat_q;
   logic signed [SUM_WIDTH-1:0] sum_w;
   logic                        clamp;

   always_comb begin
      prod_ext = ACC_WIDTH'(prod);
      term_d   = term_q;
      if (prod_valid) begin
         term_d = code ? -prod_ext : prod_ext;
      end

      // One guard bit: overflow when the two top bits of the wide sum disagree
      sum_w = SUM_WIDTH'(acc_q) + SUM_WIDTH'(term_q);
      clamp = sum_w[SUM_WIDTH-1] != sum_w[SUM_WIDTH-2];
      sum_c = sum_w[ACC_WIDTH-1:0];
      if (clamp) begin
         sum_c = sum_w[SUM_WIDTH-1] ? ACC_MIN : ACC_MAX;
      end
      sat_c = sat_q | clamp;

      acc_d = acc_q;
      sat_d = sat_q;
      if (!run) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else if (term_valid) begin
         if (term_dump) begin
            acc_d = '0;
            sat_d = 1'b0;
         end else begin
            acc_d = sum_c;
            sat_d = sat_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_q <= '0;
         acc_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         term_q <= term_d;
         acc_q  <= acc_d;
         sat_q  <= sat_d;
      end
   end

endmodule

// File: rtl/car_wipe_acc.sv
// Carrier wipe-off mixers, pipeline valids, epoch-sync FSM and valid/ack result holding for I/Q correlation.
module car_wipe_acc
   import car_pkg::*;
#(
   parameter int unsigned ADC_WIDTH = ADC_WIDTH_DEF,
   parameter int unsigned CAR_WIDTH = CAR_WIDTH_DEF,
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic                        rx_clk,
   input  logic                        rx_rst_n,
   input  logic signed [ADC_WIDTH-1:0] rx_adc_data,
   input  logic                        rx_adc_valid,
   input  logic signed [CAR_WIDTH-1:0] rx_car_cos,
   input  logic signed [CAR_WIDTH-1:0] rx_car_sin,
   input  logic                        rx_code,
   input  logic                        rx_dump,
   input  logic                        rx_ack,
   output logic signed [ACC_WIDTH-1:0] tx_acc_i,
   output logic signed [ACC_WIDTH-1:0] tx_acc_q,
   output logic                        tx_acc_valid,
   output logic                        tx_acc_sat,
   output logic                        tx_acc_ovr
);

   localparam int unsigned MUL_WIDTH = ADC_WIDTH + CAR_WIDTH;

   logic signed [MUL_WIDTH-1:0] adc_x, cos_x, sin_x;
   logic signed [MUL_WIDTH-1:0] pi_d, pi_q, pq_d, pq_q;
   logic                        p1_code_d, p1_code_q;
   logic                        p1_valid_d, p1_valid_q, p1_dump_d, p1_dump_q;
   logic                        p2_valid_d, p2_valid_q, p2_dump_d, p2_dump_q;

   acc_state_e                  acc_state_d, acc_state_q;
   out_state_e                  out_state_d, out_state_q;
   logic signed [ACC_WIDTH-1:0] acc_i_d, acc_i_q, acc_q_d, acc_q_q;
   logic                        valid_d, valid_q, sat_d, sat_q, ovr_d, ovr_q;

   logic                        run;
   logic                        dump_evt;
   logic signed [ACC_WIDTH-1:0] sum_i_c, sum_q_c;
   logic                        sat_i_c, sat_q_c;

   // P1 mixers and pipeline valids
   always_comb begin
      adc_x     = MUL_WIDTH'(rx_adc_data);
      cos_x     = MUL_WIDTH'(rx_car_cos);
      sin_x     = MUL_WIDTH'(rx_car_sin);
      pi_d      = pi_q;
      pq_d      = pq_q;
      p1_code_d = p1_code_q;
      if (rx_adc_valid) begin
         pi_d      = adc_x * cos_x;
         pq_d      = -(adc_x * sin_x);
         p1_code_d = rx_code;
      end
      p1_valid_d = rx_adc_valid;
      p1_dump_d  = rx_adc_valid & rx_dump;
      p2_valid_d = p1_valid_q;
      p2_dump_d  = p1_dump_q;
   end

   car_acc_chan #(
      .MUL_WIDTH(MUL_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
   ) u_chan_i (
      .clk       (rx_clk),
      .rst_n     (rx_rst_n),
      .prod      (pi_q),
      .code      (p1_code_q),
      .prod_valid(p1_valid_q),
      .term_valid(p2_valid_q),
      .term_dump (p2_dump_q),
      .run       (run),
      .sum_c     (sum_i_c),
      .sat_c     (sat_i_c)
   );

   car_acc_chan #(
      .MUL_WIDTH(MUL_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
   ) u_chan_q (
      .clk       (rx_clk),
      .rst_n     (rx_rst_n),
      .prod      (pq_q),
      .code      (p1_code_q),
      .prod_valid(p1_valid_q),
      .term_valid(p2_valid_q),
      .term_dump (p2_dump_q),
      .run       (run),
      .sum_c     (sum_q_c),
      .sat_c     (sat_q_c)
   );

   // Epoch sync and result hand-off FSMs
   always_comb begin
      acc_state_d = acc_state_q;
      out_state_d = out_state_q;
      acc_i_d     = acc_i_q;
      acc_q_d     = acc_q_q;
      valid_d     = valid_q;
      sat_d       = sat_q;
      ovr_d       = ovr_q;
      run         = (acc_state_q == RUN);
      dump_evt    = run & p2_valid_q & p2_dump_q;

      case (acc_state_q)
         SYNC:    if (p2_valid_q && p2_dump_q) acc_state_d = RUN;
         RUN:     acc_state_d = RUN;
         default: acc_state_d = SYNC;
      endcase

      case (out_state_q)
         IDLE: begin
            if (dump_evt) begin
               out_state_d = HOLD;
               valid_d     = 1'b1;
               acc_i_d     = sum_i_c;
               acc_q_d     = sum_q_c;
               sat_d       = sat_i_c | sat_q_c;
            end
         end
         HOLD: begin
            if (dump_evt) begin
               acc_i_d = sum_i_c;
               acc_q_d = sum_q_c;
               sat_d   = sat_i_c | sat_q_c;
               if (!rx_ack) ovr_d = 1'b1;
            end else if (rx_ack) begin
               out_state_d = IDLE;
               valid_d     = 1'b0;
            end
         end
         default: begin
            out_state_d = IDLE;
            valid_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         pi_q        <= '0;
         pq_q        <= '0;
         p1_code_q   <= 1'b0;
         p1_valid_q  <= 1'b0;
         p1_dump_q   <= 1'b0;
         p2_valid_q  <= 1'b0;
         p2_dump_q   <= 1'b0;
         acc_state_q <= SYNC;
         out_state_q <= IDLE;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         valid_q     <= 1'b0;
         sat_q       <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         pi_q        <= pi_d;
         pq_q        <= pq_d;
         p1_code_q   <= p1_code_d;
         p1_valid_q  <= p1_valid_d;
         p1_dump_q   <= p1_dump_d;
         p2_valid_q  <= p2_valid_d;
         p2_dump_q   <= p2_dump_d;
         acc_state_q <= acc_state_d;
         out_state_q <= out_state_d;
         acc_i_q     <= acc_i_d;
         acc_q_q     <= acc_q_d;
         valid_q     <= valid_d;
         sat_q       <= sat_d;
         ovr_q       <= ovr_d;
      end
   end

   assign tx_acc_i     = acc_i_q;
   assign tx_acc_q     = acc_q_q;
   assign tx_acc_valid = valid_q;
   assign tx_acc_sat   = sat_q;
   assign tx_acc_ovr   = ovr_q;

endmodule
